johnson_phase_decoder: RTL and testbench
========================================

Name: johnson_phase_decoder

Overview:
- Sits directly downstream of the team's N-bit Johnson counter.
- Consumes the counter's raw state vector and produces a registered one-hot phase, a binary phase index and legality/sequence checks.
- Also keeps a revolution counter, which downstream sequencing logic uses as a clean timing reference.
- Detects corrupt or out-of-order counter states (bad preset/clear, upset) and reports lock status.

Parameters:
N, 3, Johnson counter width; 2N legal states.
LOCK_CNT, 4, consecutive legal successor transitions required to assert locked (1..15).
REV_W, 8, width of the revolution counter.

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  asynchronous, active-low reset.
en  input  1  sample qualifier; jc_q is evaluated only on cycles with en=1.
jc_q  input  N  Johnson counter state; bit N-1 is the inverted-feedback entry bit.
err_clr  input  1  synchronous clear of err_sticky.
phase_onehot  output  2N  registered one-hot of the current phase; all-zero when the state is illegal.
phase_idx  output  clog2(2N)  registered binary phase index; 0 when the state is illegal.
valid  output  1  registered: last sampled jc_q was a legal code.
illegal  output  1  registered: last sampled jc_q was not a legal code.
seq_err  output  1  one-cycle pulse on a legal-but-out-of-order transition while locked.
err_sticky  output  1  set by illegal or seq_err; held until err_clr.
locked  output  1  sequence tracking established.
rev_cnt  output  REV_W  completed revolutions while locked; wraps modulo 2^REV_W.
rev_pulse  output  1  one-cycle pulse when rev_cnt increments.

Behaviour:
- Reset (clr=0, asynchronous): all outputs 0. Internal previous-index is 0, previous-valid is 0, lock counter is 0. clr has priority over every other input.
- Legal code map (MSB-filled Johnson):
  - idx k in 0..N: the top k bits are 1 and the rest are 0.
  - idx k in N+1..2N-1: the bottom (2N-k) bits are 1 and the rest are 0.
  - N=3 sequence: 000(0) 100(1) 110(2) 111(3) 011(4) 001(5) 000(0).
  - Any other pattern is illegal (N=3: 010, 101).
- Latency: 1 clk from a sampled jc_q to phase_onehot, phase_idx, valid and illegal. seq_err, locked, rev_cnt and rev_pulse update on the same edge.
- en=0: all registered outputs hold, except seq_err and rev_pulse, which go to 0. No checks are performed.
- Transition classes on an en=1 cycle where the previous sample was valid and the current sample is legal:
  - HOLD: cur==prev.
  - STEP: cur==(prev+1) mod 2N.
  - SKIP: anything else.
- Lock FSM states UNLOCKED, LOCKING, LOCKED:
  - UNLOCKED: the first legal sample moves to LOCKING with lock count 0.
  - LOCKING: STEP increments the lock count. Reaching LOCK_CNT moves to LOCKED and asserts locked on that edge. HOLD leaves the count unchanged. SKIP resets the count to 0 and stays in LOCKING.
  - LOCKED: HOLD and STEP stay. SKIP pulses seq_err, sets err_sticky and moves to LOCKING with count 0.
  - Any state: an illegal sample asserts illegal, sets err_sticky, deasserts locked and moves to UNLOCKED. No seq_err is raised for an illegal sample.
- Revolutions:
  - In LOCKED, a STEP from idx 2N-1 to idx 0 increments rev_cnt and pulses rev_pulse.
  - rev_cnt wraps from 2^REV_W-1 to 0, and rev_pulse still fires on the wrap.
  - rev_cnt is not cleared on loss of lock; only reset clears it.
  - The step that completes lock does not count as a revolution.
- err_sticky: if err_clr and a new error occur on the same cycle, the set wins (err_sticky=1).
- Reset deasserted mid-sequence: the first legal sample is taken as the reference, with no seq_err.

Test Plan:
1. Reset, then feed the N=3 sequence 000,100,110,111,011,001,000,... with en=1 every cycle:
   - phase_idx follows jc_q one clk later: 0,1,2,3,4,5,0.
   - locked rises after 4 STEPs.
   - The next 5→0 transition gives rev_pulse=1 and rev_cnt=1.
2. While locked, inject 101 for one cycle:
   - illegal=1, phase_onehot=0, locked=0, err_sticky=1, seq_err=0.
   - After resuming the legal sequence, relock occurs after 4 STEPs.
3. While locked, jump 110→001 (SKIP):
   - seq_err pulses for exactly 1 cycle, err_sticky=1, locked=0.
   - Assert err_clr alone: err_sticky=0 on the next edge.
4. Toggle en=0 for 3 cycles while jc_q changes arbitrarily (including 010):
   - All outputs hold and no error is flagged.
   - With en=1 and jc_q holding the same code over several cycles (HOLD), locked stays 1 and seq_err=0.
5. Set REV_W=2 and run 5 full revolutions while locked:
   - rev_cnt sequence is 1,2,3,0,1, with rev_pulse on each increment.
6. Assert clr=0 asynchronously mid-revolution, between clock edges:
   - All outputs go to 0 immediately.
   - Release clr and apply err_clr together with a new illegal sample on the same cycle: err_sticky=1.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder: one-hot/binary phase, legality and
// sequence checking, lock tracking and a revolution counter.
module johnson_phase_decoder #(
  parameter int N        = 3,
  parameter int LOCK_CNT = 4,
  parameter int REV_W    = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      en,
  input  logic [N-1:0]              jc_q,
  input  logic                      err_clr,
  output logic [2*N-1:0]            phase_onehot,
  output logic [$clog2(2*N)-1:0]    phase_idx,
  output logic                      valid,
  output logic                      illegal,
  output logic                      seq_err,
  output logic                      err_sticky,
  output logic                      locked,
  output logic [REV_W-1:0]          rev_cnt,
  output logic                      rev_pulse
);

  localparam int S  = 2 * N;
  localparam int IW = $clog2(S);
  localparam logic [IW-1:0] LAST = IW'(S - 1);
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKING,
    LOCKED
  } state_t;

  state_t state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [REV_W-1:0] rev_n;
  logic rev_p_n;
  logic seq_n;
  logic err_n;

  logic [S-1:0]  hit;
  logic [IW-1:0] cur;
  logic          legal;
  logic [IW-1:0] succ;
  logic          is_hold;
  logic          is_step;
  logic          is_skip;

  // MSB-filled Johnson code for phase k
  function automatic logic [N-1:0] code_of(input int k);
    logic [N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (k <= N) c[i] = (i >= N - k);
      else        c[i] = (i < S - k);
    end
    return c;
  endfunction

  always_comb begin
    hit   = '0;
    cur   = '0;
    legal = 1'b0;
    for (int k = 0; k < S; k++) begin
      if (jc_q == code_of(k)) begin
        hit[k] = 1'b1;
        cur    = IW'(k);
        legal  = 1'b1;
      end
    end
  end

  // valid doubles as the previous-sample-legal flag
  always_comb begin
    succ    = (phase_idx == LAST) ? '0 : phase_idx + IW'(1);
    is_hold = valid && legal && (cur == phase_idx);
    is_step = valid && legal && (cur == succ);
    is_skip = valid && legal && !is_hold && !is_step;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rev_n   = rev_cnt;
    rev_p_n = 1'b0;
    seq_n   = 1'b0;
    err_n   = err_sticky & ~err_clr;
    if (en) begin
      if (!legal) begin
        state_n = UNLOCKED;
        cnt_n   = '0;
        err_n   = 1'b1;
      end else begin
        unique case (state_q)
          UNLOCKED: begin
            state_n = LOCKING;
            cnt_n   = '0;
          end
          LOCKING: begin
            unique case (1'b1)
              is_step: begin
                cnt_n = cnt_q + 4'd1;
                if (cnt_n == LOCK_TGT) state_n = LOCKED;
              end
              is_skip: cnt_n = '0;
              default: ;
            endcase
          end
          LOCKED: begin
            unique case (1'b1)
              is_skip: begin
                seq_n   = 1'b1;
                err_n   = 1'b1;
                state_n = LOCKING;
                cnt_n   = '0;
              end
              is_step: begin
                if (phase_idx == LAST) begin
                  rev_n   = rev_cnt + REV_W'(1);
                  rev_p_n = 1'b1;
                end
              end
              default: ;
            endcase
          end
          default: begin
            state_n = UNLOCKED;
            cnt_n   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= UNLOCKED;
      cnt_q      <= '0;
      rev_cnt    <= '0;
      rev_pulse  <= 1'b0;
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      rev_cnt    <= rev_n;
      rev_pulse  <= rev_p_n;
      seq_err    <= seq_n;
      err_sticky <= err_n;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      phase_onehot <= '0;
      phase_idx    <= '0;
      valid        <= 1'b0;
      illegal      <= 1'b0;
    end else if (en) begin
      phase_onehot <= hit;
      phase_idx    <= cur;
      valid        <= legal;
      illegal      <= !legal;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_johnson_phase_decoder;

  localparam int N        = 3;
  localparam int LOCK_CNT = 4;
  localparam int REV_W    = 2;
  localparam int S        = 2 * N;
  localparam int IW       = $clog2(S);

  logic              clk;
  logic              clr;
  logic              en;
  logic [N-1:0]      jc_q;
  logic              err_clr;
  logic [S-1:0]      phase_onehot;
  logic [IW-1:0]     phase_idx;
  logic              valid;
  logic              illegal;
  logic              seq_err;
  logic              err_sticky;
  logic              locked;
  logic [REV_W-1:0]  rev_cnt;
  logic              rev_pulse;

  johnson_phase_decoder #(
    .N(N),
    .LOCK_CNT(LOCK_CNT),
    .REV_W(REV_W)
  ) dut (
    .clk(clk),
    .clr(clr),
    .en(en),
    .jc_q(jc_q),
    .err_clr(err_clr),
    .phase_onehot(phase_onehot),
    .phase_idx(phase_idx),
    .valid(valid),
    .illegal(illegal),
    .seq_err(seq_err),
    .err_sticky(err_sticky),
    .locked(locked),
    .rev_cnt(rev_cnt),
    .rev_pulse(rev_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int codes[S];
  int m_idx, m_valid, m_illegal, m_seq, m_err;
  int m_locked, m_rev, m_revp, m_track, m_streak;
  int ph;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input int v);
    for (int k = 0; k < S; k++) if (codes[k] == v) return k;
    return -1;
  endfunction

  task automatic m_reset();
    m_idx = 0; m_valid = 0; m_illegal = 0; m_seq = 0; m_err = 0;
    m_locked = 0; m_rev = 0; m_revp = 0; m_track = 0; m_streak = 0;
  endtask

  task automatic model_step(input bit e, input int v, input bit ec);
    int k;
    int err_next;
    bit is_step;
    bit is_hold;
    err_next = (ec) ? 0 : m_err;
    m_seq  = 0;
    m_revp = 0;
    if (e) begin
      k = lookup(v);
      if (k < 0) begin
        m_valid = 0; m_illegal = 1; m_idx = 0;
        m_locked = 0; m_track = 0; m_streak = 0;
        err_next = 1;
      end else begin
        is_hold = (k == m_idx);
        is_step = (k == (m_idx + 1) % S);
        if (!m_track) begin
          m_track = 1; m_streak = 0;
        end else if (m_locked) begin
          if (is_step && m_idx == S - 1) begin
            m_rev  = (m_rev + 1) % (1 << REV_W);
            m_revp = 1;
          end else if (!is_step && !is_hold) begin
            m_seq = 1; err_next = 1;
            m_locked = 0; m_streak = 0;
          end
        end else if (is_step) begin
          m_streak++;
          if (m_streak == LOCK_CNT) m_locked = 1;
        end else if (!is_hold) begin
          m_streak = 0;
        end
        m_idx = k; m_valid = 1; m_illegal = 0;
      end
    end
    m_err = err_next;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".onehot"}, int'(phase_onehot), m_valid ? (1 << m_idx) : 0);
    chk({tag, ".idx"}, int'(phase_idx), m_idx);
    chk({tag, ".valid"}, int'(valid), m_valid);
    chk({tag, ".illegal"}, int'(illegal), m_illegal);
    chk({tag, ".seq_err"}, int'(seq_err), m_seq);
    chk({tag, ".err_sticky"}, int'(err_sticky), m_err);
    chk({tag, ".locked"}, int'(locked), m_locked);
    chk({tag, ".rev_cnt"}, int'(rev_cnt), m_rev);
    chk({tag, ".rev_pulse"}, int'(rev_pulse), m_revp);
  endtask

  task automatic cyc(input string tag, input bit e, input int v, input bit ec);
    en      = e;
    jc_q    = N'(v);
    err_clr = ec;
    @(posedge clk);
    model_step(e, v, ec);
    #1;
    check_all(tag);
  endtask

  task automatic adv(input string tag);
    cyc(tag, 1'b1, codes[ph], 1'b0);
    ph = (ph + 1) % S;
  endtask

  initial begin
    for (int k = 0; k < S; k++)
      codes[k] = (k <= N) ? (((1 << k) - 1) << (N - k))
                          : ((1 << (S - k)) - 1);
    m_reset();
    ph = 0;
    clr = 1'b1; en = 1'b0; jc_q = '0; err_clr = 1'b0;
    #2 clr = 1'b0;
    #2 check_all("reset");
    #4 clr = 1'b1;

    // 1: clean sequence, lock and first revolution
    for (int i = 0; i < 12; i++) adv("seq");
    chk("t1_locked", int'(locked), 1);

    // 2: illegal 101 while locked, then relock
    cyc("illegal", 1'b1, 5, 1'b0);
    chk("t2_illegal", int'(illegal), 1);
    for (int i = 0; i < 8; i++) adv("relock");

    // 3: skip 110 -> 001 while locked, then err_clr alone
    while (ph != 3) adv("pre_skip");
    cyc("skip", 1'b1, codes[5], 1'b0);
    chk("t3_seq_err", int'(seq_err), 1);
    ph = 0;
    adv("post_skip");
    cyc("err_clr", 1'b0, 0, 1'b1);
    chk("t3_err_clear", int'(err_sticky), 0);
    for (int i = 0; i < 8; i++) adv("relock2");

    // 4: en low with garbage, then holds
    cyc("en_off", 1'b0, 2, 1'b0);
    cyc("en_off", 1'b0, $urandom_range(0, 7), 1'b0);
    cyc("en_off", 1'b0, 5, 1'b0);
    ph = (ph + S - 1) % S;
    for (int i = 0; i < 4; i++) cyc("hold", 1'b1, codes[ph], 1'b0);
    ph = (ph + 1) % S;

    // 5: five revolutions with 2-bit wrap
    for (int i = 0; i < 5 * S; i++) adv("revs");

    // 6: async reset mid-cycle, then err_clr racing an illegal sample
    adv("pre_rst");
    #2 clr = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    #3 clr = 1'b1;
    cyc("clr_vs_err", 1'b1, 2, 1'b1);
    chk("t6_err_set_wins", int'(err_sticky), 1);

    // randomized traffic
    ph = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      int v;
      bit e;
      bit ec;
      r  = $urandom_range(0, 99);
      e  = ($urandom_range(0, 9) != 0);
      ec = ($urandom_range(0, 9) == 0);
      if (r < 80) begin
        v  = codes[ph];
        if (e) ph = (ph + 1) % S;
      end else if (r < 88) begin
        v = codes[(ph + S - 1) % S];
      end else if (r < 94) begin
        v  = codes[$urandom_range(0, S - 1)];
      end else begin
        v = $urandom_range(0, (1 << N) - 1);
      end
      cyc("rand", e, v, ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
